// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU core and the debug/loader port.
// CPU has fixed priority; a starvation counter forces a debug grant after MAX_WAIT denials.
module mem_port_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_halt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  // Handshake: a requester holds req/we/addr/wdata stable until it sees gnt in the
  // same cycle; each gnt consumes exactly one access, and a read's data arrives
  // with a one-cycle rvalid pulse on the following cycle.
  typedef enum logic [1:0] {RSP_NONE, RSP_CPU, RSP_DBG} rsp_owner_t;

  rsp_owner_t        rsp_owner, rsp_owner_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              dbg_pri;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_owner <= RSP_NONE;
      wait_cnt  <= '0;
    end else begin
      rsp_owner <= rsp_owner_next;
      wait_cnt  <= wait_cnt_next;
    end
  end

  // Arbitration and next-state
  always_comb begin
    dbg_pri        = cpu_halt | (wait_cnt == WAIT_W'(MAX_WAIT));
    dbg_gnt        = reset & dbg_req & (dbg_pri | ~cpu_req);
    cpu_gnt        = reset & cpu_req & ~dbg_gnt;
    rsp_owner_next = RSP_NONE;
    if (dbg_gnt && !dbg_we)      rsp_owner_next = RSP_DBG;
    else if (cpu_gnt && !cpu_we) rsp_owner_next = RSP_CPU;
    wait_cnt_next = '0;
    if (dbg_req && !dbg_gnt) begin
      if (wait_cnt == WAIT_W'(MAX_WAIT)) wait_cnt_next = wait_cnt;
      else                               wait_cnt_next = wait_cnt + WAIT_W'(1);
    end
  end

  // Outputs: memory command mux and read-response steering
  always_comb begin
    mem_en     = cpu_gnt | dbg_gnt;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
    cpu_rvalid = (rsp_owner == RSP_CPU);
    dbg_rvalid = (rsp_owner == RSP_DBG);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors plus an every-cycle reference model
// of arbitration, starvation and read responses, backed by a 16x8 synchronous memory.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 4;

  logic              clk;
  logic              reset;
  logic              cpu_halt, cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
  logic              cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .cpu_halt(cpu_halt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory attached to the arbiter
  logic [DATA_W-1:0] mem_arr [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic c_req, input logic c_we, input logic [ADDR_W-1:0] c_addr,
                       input logic [DATA_W-1:0] c_wd, input logic d_req, input logic d_we,
                       input logic [ADDR_W-1:0] d_addr, input logic [DATA_W-1:0] d_wd,
                       input logic halt);
    @(posedge clk);
    #1;
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
    cpu_halt = halt;
  endtask

  task automatic set_reset(input logic r);
    @(posedge clk);
    #1;
    reset = r;
  endtask

  // Reference model: a shadow memory, a count of consecutive denied debug cycles
  // and a scoreboard of expected read responses {is_dbg, data}.
  logic [DATA_W-1:0] ref_mem [16];
  logic [DATA_W:0]   exp_q [$];
  int                denied = 0;

  always @(negedge clk) begin
    logic          exp_dbg, exp_cpu, has_rsp;
    logic [DATA_W:0] rsp;
    if (!reset) begin
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_dbg_gnt", dbg_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_dbg_rvalid", dbg_rvalid, 0);
      denied = 0;
      exp_q.delete();
    end else begin
      has_rsp = (exp_q.size() > 0);
      rsp = has_rsp ? exp_q.pop_front() : '0;
      chk("cpu_rvalid", cpu_rvalid, has_rsp && !rsp[DATA_W]);
      chk("dbg_rvalid", dbg_rvalid, has_rsp && rsp[DATA_W]);
      chk("cpu_rdata", cpu_rdata, (has_rsp && !rsp[DATA_W]) ? rsp[DATA_W-1:0] : 0);
      chk("dbg_rdata", dbg_rdata, (has_rsp && rsp[DATA_W]) ? rsp[DATA_W-1:0] : 0);

      exp_dbg = dbg_req && (cpu_halt || denied >= MAX_WAIT || !cpu_req);
      exp_cpu = cpu_req && !exp_dbg;
      chk("cpu_gnt", cpu_gnt, exp_cpu);
      chk("dbg_gnt", dbg_gnt, exp_dbg);
      chk("mem_en", mem_en, exp_cpu || exp_dbg);
      chk("mem_we", mem_we, exp_dbg ? dbg_we : (exp_cpu ? cpu_we : 0));
      chk("mem_addr", mem_addr, exp_dbg ? dbg_addr : (exp_cpu ? cpu_addr : 0));
      chk("mem_wdata", mem_wdata, exp_dbg ? dbg_wdata : (exp_cpu ? cpu_wdata : 0));

      if (exp_dbg) begin
        if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
        else        exp_q.push_back({1'b1, ref_mem[dbg_addr]});
      end else if (exp_cpu) begin
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else        exp_q.push_back({1'b0, ref_mem[cpu_addr]});
      end
      denied = (dbg_req && !exp_dbg) ? denied + 1 : 0;
    end
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = DATA_W'(i * 17);
      ref_mem[i] = DATA_W'(i * 17);
    end
    mem_arr[3] = 8'hA5;
    ref_mem[3] = 8'hA5;
    mem_rdata = '0;
    reset = 1'b0;
    cpu_halt = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;

    // Grants held off in reset, first grant in the release cycle
    repeat (2) @(negedge clk);
    chk("t1_gnt_in_reset", cpu_gnt, 0);
    chk("t1_mem_en_in_reset", mem_en, 0);
    set_reset(1'b1);
    @(negedge clk);
    chk("t1_gnt_after_release", cpu_gnt, 1);

    // CPU read of address 3
    drive(1, 0, 4'h3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t2_gnt", cpu_gnt, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t2_rvalid", cpu_rvalid, 1);
    chk("t2_rdata", cpu_rdata, 8'hA5);

    // Both requesting: four CPU grants, then one forced debug grant, repeating
    drive(1, 0, 4'h1, 0, 1, 0, 4'h2, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_cpu_pattern", cpu_gnt, (i % 5) != 4);
      chk("t3_dbg_pattern", dbg_gnt, (i % 5) == 4);
    end

    // Halted CPU: debug always wins
    drive(1, 0, 4'h1, 0, 1, 0, 4'h3, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_dbg_gnt", dbg_gnt, 1);
      chk("t4_cpu_gnt", cpu_gnt, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_dbg_rdata", dbg_rdata, 8'hA5);

    // Debug write then CPU read of the same address next cycle
    drive(0, 0, 0, 0, 1, 1, 4'hF, 8'h3C, 0);
    @(negedge clk);
    chk("t5_dbg_wr_gnt", dbg_gnt, 1);
    chk("t5_mem_we", mem_we, 1);
    drive(1, 0, 4'hF, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5_rvalid", cpu_rvalid, 1);
    chk("t5_rdata", cpu_rdata, 8'h3C);

    // Read in flight dropped by reset
    drive(1, 0, 4'h3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t6_gnt", cpu_gnt, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rvalid_in_reset", cpu_rvalid, 0);
    set_reset(1'b1);
    @(negedge clk);
    chk("t6_rvalid_after_release", cpu_rvalid, 0);

    // Mixed traffic, checked cycle-by-cycle by the model
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 7) == 0));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
